// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - parametrised valid/ready register pipeline with bubble collapsing, flush and occupancy
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; empties the chain, data regs to RESET_VAL
//   flush      synchronous clear of every stage valid bit (data regs untouched)
//   in_valid   producer presents in_data
//   in_ready   chain accepts in_data this cycle
//   in_data    input word
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts out_data this cycle
//   out_data   data register of the last stage
//   occupancy  number of valid stages, 0..DEPTH
module pipe_reg_chain #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];

    // Stage i can advance when the consumer is taking a word or when any
    // stage from i to the output is empty (a bubble absorbs the shift).
    // This is the unrolled form of rdy[i] = !v[i] || rdy[i+1], written
    // without a self-referencing vector.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
        assign rdy[g] = out_ready || !(&v[DEPTH-1:g]);
    end

    always_comb begin
        up_v[0] = in_valid && !flush;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= up_v[i];
                    // Data only moves with a valid word so that bubbles
                    // never disturb the last value held in a register.
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed self-checking bench for pipe_reg_chain
module tb_pipe_reg_chain;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, RV); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        reset = 1'b1;
    endtask

    task automatic test_streaming;
        logic       exp_v;
        logic [1:0] exp_occ;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 16);
            in_data  = 8'(k + 1);
            #1;
            exp_v   = (k >= 3) && (k <= 18);
            exp_occ = (k <= 3) ? 2'(k) : ((k <= 16) ? 2'd3 : 2'(19 - k));
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got %b exp 1", k, in_ready); end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_out_valid k=%0d got %b exp %b", k, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_data !== 8'(k - 2)) begin errors++; $display("FAIL stream_out_data k=%0d got %h exp %h", k, out_data, 8'(k - 2)); end
            end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL stream_occupancy k=%0d got %0d exp %0d", k, occupancy, exp_occ); end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = vals[k];
            #1;
            checks++; if (in_ready !== (k < 3)) begin errors++; $display("FAIL bp_in_ready k=%0d got %b exp %b", k, in_ready, (k < 3)); end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL bp_occupancy k=%0d got %0d exp 3", k, occupancy); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready k=%0d got %b exp 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL bp_held k=%0d got %b/%h exp 1/11", k, out_valid, out_data); end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== vals[k]) begin errors++; $display("FAIL bp_drain k=%0d got %b/%h exp 1/%h", k, out_valid, out_data, vals[k]); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got %b/%0d exp 0/0", out_valid, occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_bubble_collapse;
        logic [7:0] vals [3];
        vals = '{8'h55, 8'h66, 8'h77};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL bubble_setup got %0d/%b/%h exp 1/1/55", occupancy, out_valid, out_data); end
        in_valid = 1'b1;
        for (int k = 1; k < 3; k++) begin
            in_data = vals[k];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready k=%0d got %b exp 1", k, in_ready); end
            tick();
        end
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL bubble_occupancy got %0d exp 3", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_full_in_ready got %b exp 0", in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== vals[k]) begin errors++; $display("FAIL bubble_drain k=%0d got %b/%h exp 1/%h", k, out_valid, out_data, vals[k]); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = 8'(8'hC1 + j);
            tick();
        end
        in_data = 8'hC4;
        #1;
        checks++; if (in_ready !== 1'b0 || occupancy !== 2'd3) begin errors++; $display("FAIL pp_full got %b/%0d exp 0/3", in_ready, occupancy); end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 8'(8'hC4 + j);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_in_ready j=%0d got %b exp 1", j, in_ready); end
            checks++; if (out_data !== 8'(8'hC1 + j)) begin errors++; $display("FAIL pp_out_data j=%0d got %h exp %h", j, out_data, 8'(8'hC1 + j)); end
            checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL pp_occupancy j=%0d got %0d exp 3", j, occupancy); end
            tick();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'hC5 + j)) begin errors++; $display("FAIL pp_drain j=%0d got %b/%h exp 1/%h", j, out_valid, out_data, 8'(8'hC5 + j)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL pp_empty got %b/%0d exp 0/0", out_valid, occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h81;
        tick();
        in_data = 8'h82;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h81) begin errors++; $display("FAIL flush_setup got %0d/%b/%h exp 2/1/81", occupancy, out_valid, out_data); end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h83;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occupancy got %0d exp 0", occupancy); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emerge k=%0d got %b exp 0 (data %h)", k, out_valid, out_data); end
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h90;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h90 || occupancy !== 2'd1) begin errors++; $display("FAIL flush_after got %b/%h/%0d exp 1/90/1", out_valid, out_data, occupancy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin errors++; $display("FAIL mid_setup got %b/%h exp 1/31", out_valid, out_data); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b exp 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL mid_reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL mid_reset_out_data got %h exp %h", out_data, RV); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b exp 1", in_ready); end
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL mid_reset_after got %b/%0d exp 0/0", out_valid, occupancy); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_full_push_pop();
        test_flush();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised multi-stage register pipeline with a per-stage valid bit and valid/ready backpressure. It is the successor to the single-bit asynchronous-reset D flip-flop: WIDTH-bit data, DEPTH stages, and bubble collapsing. It adds a synchronous flush and an occupancy count. It sits between producer and consumer blocks that need timing isolation with flow control and no data loss.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 3, number of register stages (≥1)
- RESET_VAL, 0, WIDTH-bit value loaded into every data register on reset
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all stage valid bits
- in_valid  input  1  producer has data on in_data
- in_ready  output  1  chain accepts in_data this cycle
- in_data  input  WIDTH  input word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  output word; this is the data register of stage DEPTH-1
- occupancy  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- State per stage i (0..DEPTH-1): valid bit v[i] and data register d[i]. Stage 0 is nearest the input.
- Readiness is combinational from the output back to the input:
  - rdy[DEPTH] = out_ready
  - rdy[i] = !v[i] || rdy[i+1]
- Upstream valid for each stage: up_v[0] = in_valid && !flush; up_v[i] = v[i-1] for i > 0.
- Stage update, when flush = 0 and rdy[i] = 1:
  - v[i] <= up_v[i]
  - d[i] <= upstream data, but only if up_v[i] = 1
  - otherwise d[i] holds its value
- A stage with rdy[i] = 0 holds both v[i] and d[i].
- Bubble collapsing: an empty stage always accepts, even when downstream is stalled.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - An input word is never dropped or duplicated. Words leave in arrival order.
- Output gating:
  - in_ready = rdy[0] && !flush
  - out_valid = v[DEPTH-1] && !flush
  - out_data = d[DEPTH-1]; out_data is stable while out_valid && !out_ready.
- Flush (synchronous, highest priority): on the next edge all v[i] go to 0 and d[i] are unchanged. No transfer occurs in a flush cycle.
- occupancy = popcount(v), combinational from the registered valid bits.
- Reset (reset = 0, asynchronous, takes effect immediately) sets:
  - all v[i] = 0
  - all d[i] = RESET_VAL
  - out_valid = 0, out_data = RESET_VAL, occupancy = 0
  - in_ready = !flush (the chain is empty), so with flush = 0 in_ready = 1.
- Reset mid-operation discards all stored words. Deassertion needs no special sequencing.
- DEPTH = 1 degenerates to a single valid/ready register. in_ready = !v[0] || out_ready.

## Timing
- Latency with no stall: a word accepted at edge N appears on out_data with out_valid = 1 after edge N+DEPTH-1, i.e. it is presented in cycle N+DEPTH. This is DEPTH cycles.
- Throughput: 1 word/cycle sustained while out_ready = 1.
- Combinational paths:
  - out_ready → in_ready (through the rdy chain)
  - flush → in_ready / out_valid
  - No path from in_valid to in_ready.
- Full condition: occupancy = DEPTH with out_ready = 0 gives in_ready = 0.
- Simultaneous push and pop when full: out_ready = 1 makes in_ready = 1. Occupancy is unchanged after the edge.
- Simultaneous push and pop when occupancy < DEPTH is legal. Occupancy changes by push − pop, after the bubble shifts.
- No internal counters exist, so there is no wrap-around case.

## Test plan
- Reset check: assert reset = 0 mid-stream with WIDTH=8, DEPTH=3, RESET_VAL=8'hA5 → immediately out_valid=0, occupancy=0, out_data=8'hA5, in_ready=1.
- Streaming: push 8'h01..8'h10 with out_ready=1 continuously → first word appears on out_data 3 cycles after acceptance; then one word per cycle in order; occupancy stays 3 in steady state.
- Backpressure fill: out_ready=0, push 8'h11, 8'h22, 8'h33, 8'h44 → first three accepted, in_ready=0 on the fourth, occupancy=3, out_data=8'h11 held stable.
- Bubble collapse: with stage 2 valid and stalled and stages 0..1 empty, push two words → both accepted on consecutive cycles and occupancy reaches 3 while out_ready=0.
- Full push/pop: chain full, raise out_ready=1 and in_valid=1 → in_ready=1 the same cycle, one word out and one in per cycle, occupancy stays 3, order preserved.
- Flush: occupancy=2, assert flush for 1 cycle with in_valid=1 → in_ready=0 and out_valid=0 during flush; occupancy=0 next cycle; no flushed or input word ever emerges.
